bg_ram_writer: RTL and testbench

// Writer end of the 320x240x4 background frame RAM. Decodes a run-length byte stream
// (or a solid-fill command) into one 4-bit palette-index write per cycle, at the

---
 rtl/bg_pkg.sv | 25 ++
 rtl/bg_rle_unpack.sv | 33 +++
 rtl/bg_ram_writer.sv | 120 ++++++++++++
 tb/tb_bg_ram_writer.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/bg_pkg.sv
// Shared background-frame constants and types. The VGA-side readers use the same addressing.
package bg_pkg;

  localparam int RESHAPE_LENGTH = 320;
  localparam int RESHAPE_HEIGHT = 240;
  localparam int NUM_PIXELS     = RESHAPE_LENGTH * RESHAPE_HEIGHT;

  typedef logic [16:0] addr_t;
  typedef logic [3:0]  pix_t;
  typedef logic [4:0]  run_t;

  // One stream byte: upper nibble is the run length minus one, lower nibble is the palette index.
  typedef struct packed {
    logic [3:0] len_m1;
    pix_t       colour;
  } rle_byte_t;

  typedef logic [2:0] wr_state_t;
  localparam wr_state_t ST_IDLE  = 3'd0;
  localparam wr_state_t ST_FETCH = 3'd1;
  localparam wr_state_t ST_RUN   = 3'd2;
  localparam wr_state_t ST_FILL  = 3'd3;
  localparam wr_state_t ST_DONE  = 3'd4;

endpackage

// File: rtl/bg_rle_unpack.sv
// Colour and pixels-left register pair, loaded from a stream byte or a fill colour.
// Loads take effect on the next edge. There is no backpressure: the caller decides when to load or decrement.
module bg_rle_unpack (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic       ld_byte,
  input  logic [7:0] byte_dat,
  input  logic       ld_fill,
  input  logic [3:0] fill_color,
  input  logic       dec,
  output logic [3:0] colour,
  output logic [4:0] remaining
);
  import bg_pkg::*;

  rle_byte_t rle;
  assign rle = rle_byte_t'(byte_dat);

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      colour    <= '0;
      remaining <= '0;
    end else if (ld_fill) begin
      colour <= fill_color;
    end else if (ld_byte) begin
      colour    <= rle.colour;
      remaining <= run_t'(rle.len_m1) + 5'd1;
    end else if (dec) begin
      remaining <= remaining - 5'd1;
    end
  end

endmodule

// File: rtl/bg_ram_writer.sv
// RLE or solid-fill writer for the background RAM. It writes one pixel per cycle at x + y*RESHAPE_LENGTH.
// A byte accepted in cycle N is written in cycles N+1..N+L. in_ready is high only while waiting for the next byte.
module bg_ram_writer #(
  parameter int RESHAPE_LENGTH = bg_pkg::RESHAPE_LENGTH,
  parameter int RESHAPE_HEIGHT = bg_pkg::RESHAPE_HEIGHT
) (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic        load_start,
  input  logic        fill_start,
  input  logic [3:0]  fill_color,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  output logic        wr_en,
  output logic [16:0] wr_addr,
  output logic [3:0]  wr_data,
  output logic        busy,
  output logic        done,
  output logic        overrun
);
  import bg_pkg::*;

  localparam addr_t LAST_ADDR = addr_t'(RESHAPE_LENGTH * RESHAPE_HEIGHT - 1);

  wr_state_t state;
  addr_t     addr;
  addr_t     wr_addr_q;
  logic      wr_en_q;
  logic      overrun_q;
  pix_t      colour;
  run_t      remaining;
  logic      hs;
  logic      at_last;

  assign in_ready = (state == ST_FETCH);
  assign busy     = (state != ST_IDLE);
  assign done     = (state == ST_DONE);
  assign hs       = in_valid & in_ready;
  assign at_last  = (wr_addr_q == LAST_ADDR);

  assign wr_en   = wr_en_q;
  assign wr_addr = wr_addr_q;
  assign wr_data = colour;
  assign overrun = overrun_q;

  bg_rle_unpack u_unpack (
    .Clk        (Clk),
    .Reset_n    (Reset_n),
    .ld_byte    (hs),
    .byte_dat   (in_data),
    .ld_fill    ((state == ST_IDLE) && fill_start),
    .fill_color (fill_color),
    .dec        (state == ST_RUN),
    .colour     (colour),
    .remaining  (remaining)
  );

  // wr_en/wr_addr describe the write happening in the current cycle, so every state
  // transition also sets up the next cycle's write strobe.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state     <= ST_IDLE;
      addr      <= '0;
      wr_addr_q <= '0;
      wr_en_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (fill_start) begin
            state     <= ST_FILL;
            wr_en_q   <= 1'b1;
            wr_addr_q <= '0;
            overrun_q <= 1'b0;
          end else if (load_start) begin
            state     <= ST_FETCH;
            addr      <= '0;
            overrun_q <= 1'b0;
          end
        end
        ST_FETCH: begin
          if (hs) begin
            state     <= ST_RUN;
            wr_en_q   <= 1'b1;
            wr_addr_q <= addr;
          end
        end
        ST_RUN: begin
          // The frame end takes priority over the run count. Pixels beyond the last address are dropped.
          if (at_last) begin
            state   <= ST_DONE;
            wr_en_q <= 1'b0;
            if (remaining > 5'd1) overrun_q <= 1'b1;
          end else if (remaining == 5'd1) begin
            state   <= ST_FETCH;
            wr_en_q <= 1'b0;
            addr    <= wr_addr_q + 17'd1;
          end else begin
            wr_addr_q <= wr_addr_q + 17'd1;
          end
        end
        ST_FILL: begin
          if (at_last) begin
            state   <= ST_DONE;
            wr_en_q <= 1'b0;
          end else begin
            wr_addr_q <= wr_addr_q + 17'd1;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: begin
          state   <= ST_IDLE;
          wr_en_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bg_ram_writer.sv
// Scoreboard bench: the full-size writer covers reset and a full-frame fill; a 16x4 writer covers stream edge cases.
module tb_bg_ram_writer;
  import bg_pkg::*;

  localparam int SL     = 16;
  localparam int SH     = 4;
  localparam int S_LAST = SL * SH - 1;
  localparam int B_LAST = NUM_PIXELS - 1;

  logic Clk = 1'b0;
  always #5 Clk = ~Clk;
  logic Reset_n;

  logic        b_load_start, b_fill_start, b_in_valid;
  logic [3:0]  b_fill_color;
  logic [7:0]  b_in_data;
  logic        b_in_ready, b_wr_en, b_busy, b_done, b_overrun;
  logic [16:0] b_wr_addr;
  logic [3:0]  b_wr_data;

  logic        s_load_start, s_fill_start, s_in_valid;
  logic [3:0]  s_fill_color;
  logic [7:0]  s_in_data;
  logic        s_in_ready, s_wr_en, s_busy, s_done, s_overrun;
  logic [16:0] s_wr_addr;
  logic [3:0]  s_wr_data;

  bg_ram_writer u_big (
    .Clk(Clk), .Reset_n(Reset_n), .load_start(b_load_start), .fill_start(b_fill_start),
    .fill_color(b_fill_color), .in_valid(b_in_valid), .in_data(b_in_data), .in_ready(b_in_ready),
    .wr_en(b_wr_en), .wr_addr(b_wr_addr), .wr_data(b_wr_data), .busy(b_busy), .done(b_done),
    .overrun(b_overrun)
  );

  bg_ram_writer #(.RESHAPE_LENGTH(SL), .RESHAPE_HEIGHT(SH)) u_small (
    .Clk(Clk), .Reset_n(Reset_n), .load_start(s_load_start), .fill_start(s_fill_start),
    .fill_color(s_fill_color), .in_valid(s_in_valid), .in_data(s_in_data), .in_ready(s_in_ready),
    .wr_en(s_wr_en), .wr_addr(s_wr_addr), .wr_data(s_wr_data), .busy(s_busy), .done(s_done),
    .overrun(s_overrun)
  );

  int total = 0;
  int bad   = 0;
  logic [20:0] bq[$];
  logic [20:0] sq[$];
  int b_done_cnt = 0;
  int s_done_cnt = 0;
  int s_wr_cnt   = 0;
  int s_ma;
  logic s_exp_ovr;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, want %0h", tag, got, exp);
    end
  endtask

  always @(negedge Clk) begin
    logic [20:0] e;
    if (b_done) b_done_cnt++;
    if (b_wr_en) begin
      if (bq.size() == 0) chk("b_unexpected_wr", {11'd0, b_wr_addr, b_wr_data}, 32'hFFFF_FFFF);
      else begin
        e = bq.pop_front();
        chk("b_wr", {11'd0, b_wr_addr, b_wr_data}, {11'd0, e});
      end
    end
  end

  always @(negedge Clk) begin
    logic [20:0] e;
    if (s_done) s_done_cnt++;
    if (s_wr_en) begin
      s_wr_cnt++;
      if (sq.size() == 0) chk("s_unexpected_wr", {11'd0, s_wr_addr, s_wr_data}, 32'hFFFF_FFFF);
      else begin
        e = sq.pop_front();
        chk("s_wr", {11'd0, s_wr_addr, s_wr_data}, {11'd0, e});
      end
    end
  end

  task automatic s_start_load();
    s_ma = 0;
    s_exp_ovr = 1'b0;
    s_load_start = 1'b1;
    @(negedge Clk);
    s_load_start = 1'b0;
  endtask

  // Called at a negedge; returns at the negedge after the byte is accepted.
  task automatic s_send(input logic [7:0] b);
    int n;
    for (int i = 0; i <= int'(b[7:4]); i++) begin
      if (s_ma <= S_LAST) begin
        sq.push_back({17'(s_ma), b[3:0]});
        s_ma++;
      end else begin
        s_exp_ovr = 1'b1;
      end
    end
    s_in_valid = 1'b1;
    s_in_data  = b;
    n = 0;
    while (!s_in_ready && n < 200) begin
      @(negedge Clk);
      n++;
    end
    if (!s_in_ready) chk("s_accept_timeout", {31'd0, s_in_ready}, 1);
    @(negedge Clk);
    s_in_valid = 1'b0;
  endtask

  task automatic s_wait_done(input string tag);
    int n;
    int d0;
    d0 = s_done_cnt;
    n = 0;
    while (!s_done && n < 500) begin
      @(negedge Clk);
      n++;
    end
    chk(tag, {31'd0, s_done}, 1);
    repeat (2) @(negedge Clk);
    chk({tag, "_once"}, s_done_cnt - d0, 1);
    chk({tag, "_ovr"}, {31'd0, s_overrun}, {31'd0, s_exp_ovr});
    chk({tag, "_drain"}, sq.size(), 0);
    chk({tag, "_idle"}, {31'd0, s_busy}, 0);
  endtask

  initial begin
    int n;
    int d0;
    int w0;
    Reset_n = 1'b0;
    {b_load_start, b_fill_start, b_in_valid, b_fill_color, b_in_data} = '0;
    {s_load_start, s_fill_start, s_in_valid, s_fill_color, s_in_data} = '0;
    s_ma = 0;
    s_exp_ovr = 1'b0;
    repeat (2) @(negedge Clk);
    chk("rst_wr_en", {31'd0, b_wr_en}, 0);
    chk("rst_busy", {31'd0, b_busy}, 0);
    chk("rst_done", {31'd0, b_done}, 0);
    chk("rst_overrun", {31'd0, b_overrun}, 0);
    chk("rst_in_ready", {31'd0, b_in_ready}, 0);
    chk("rst_wr_addr", {15'd0, b_wr_addr}, 0);
    chk("rst_wr_data", {28'd0, b_wr_data}, 0);
    chk("rst_s_busy", {31'd0, s_busy}, 0);
    Reset_n = 1'b1;
    @(negedge Clk);

    // Reset asserted in the middle of a fill
    b_fill_color = 4'h3;
    b_fill_start = 1'b1;
    for (int a = 0; a <= 100; a++) bq.push_back({17'(a), 4'h3});
    @(negedge Clk);
    b_fill_start = 1'b0;
    n = 0;
    while (b_wr_addr != 17'd100 && n < 300) begin
      @(negedge Clk);
      n++;
    end
    chk("rstfill_addr", {15'd0, b_wr_addr}, 100);
    #1 Reset_n = 1'b0;
    #1;
    chk("rstfill_wr_en", {31'd0, b_wr_en}, 0);
    chk("rstfill_busy", {31'd0, b_busy}, 0);
    chk("rstfill_drain", bq.size(), 0);
    @(negedge Clk);
    Reset_n = 1'b1;
    @(negedge Clk);
    chk("rstfill_addr0", {15'd0, b_wr_addr}, 0);
    chk("rstfill_idle", {31'd0, b_busy}, 0);
    chk("rstfill_no_wr", {31'd0, b_wr_en}, 0);

    // Full-frame fill with colour A
    b_fill_color = 4'hA;
    b_fill_start = 1'b1;
    for (int a = 0; a <= B_LAST; a++) bq.push_back({17'(a), 4'hA});
    @(negedge Clk);
    b_fill_start = 1'b0;
    b_fill_color = 4'h0;
    d0 = b_done_cnt;
    n = 0;
    while (!b_done && n < 80000) begin
      @(negedge Clk);
      n++;
    end
    chk("fill_done", {31'd0, b_done}, 1);
    chk("fill_drain", bq.size(), 0);
    repeat (2) @(negedge Clk);
    chk("fill_done_once", b_done_cnt - d0, 1);
    chk("fill_idle", {31'd0, b_busy}, 0);
    chk("fill_overrun", {31'd0, b_overrun}, 0);

    // Two-byte stream with in_ready timing, an ignored restart, and a valid gap
    s_start_load();
    s_send(8'h32);
    for (int i = 0; i < 4; i++) begin
      chk("rdy_low_in_run", {31'd0, s_in_ready}, 0);
      @(negedge Clk);
    end
    chk("rdy_back", {31'd0, s_in_ready}, 1);
    s_send(8'h05);
    s_send(8'hF7);
    s_load_start = 1'b1;
    @(negedge Clk);
    s_load_start = 1'b0;
    s_fill_start = 1'b1;
    s_fill_color = 4'hC;
    @(negedge Clk);
    s_fill_start = 1'b0;
    n = 0;
    while (!s_in_ready && n < 100) begin
      @(negedge Clk);
      n++;
    end
    for (int i = 0; i < 3; i++) begin
      chk("gap_no_wr", {31'd0, s_wr_en}, 0);
      chk("gap_rdy", {31'd0, s_in_ready}, 1);
      @(negedge Clk);
    end
    s_send(8'hF7);
    s_send(8'hF7);
    s_send(8'hA7);
    s_wait_done("mix");

    // Exact-fit stream: 4 runs of 16 pixels
    w0 = s_wr_cnt;
    s_start_load();
    for (int i = 0; i < 4; i++) s_send(8'hF7);
    s_wait_done("full");
    chk("full_wr_cnt", s_wr_cnt - w0, 64);

    // Last run crosses the frame end with 10 pixels left
    s_start_load();
    for (int i = 0; i < 3; i++) s_send(8'hF7);
    s_send(8'h57);
    s_send(8'hF9);
    s_wait_done("trunc");
    s_in_valid = 1'b1;
    s_in_data  = 8'h11;
    for (int i = 0; i < 5; i++) begin
      chk("trunc_rdy_low", {31'd0, s_in_ready}, 0);
      @(negedge Clk);
    end
    s_in_valid = 1'b0;
    chk("trunc_ovr_sticky", {31'd0, s_overrun}, 1);

    // Fill and load in the same cycle: the fill is taken and overrun clears
    s_fill_color = 4'h5;
    s_fill_start = 1'b1;
    s_load_start = 1'b1;
    s_exp_ovr = 1'b0;
    for (int a = 0; a <= S_LAST; a++) sq.push_back({17'(a), 4'h5});
    @(negedge Clk);
    s_fill_start = 1'b0;
    s_load_start = 1'b0;
    chk("both_ovr_clr", {31'd0, s_overrun}, 0);
    chk("both_fill_busy", {31'd0, s_busy}, 1);
    chk("both_no_rdy", {31'd0, s_in_ready}, 0);
    s_wait_done("both");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
